config_loader: RTL and testbench

Byte-serial configuration front-end for the LFSR pixel generator. It collects the seed word and then the stop word from an 8-bit byte stream, which is the chip's narrow input port. Each word is assembled to MAX_PIXEL_BITS width and presented to the LFSR block with a one-cycle ready strobe and the correct seed/stop select. The loader then waits for the LFSR's registered acknowledge before moving on.

---
 rtl/config_loader_pkg.sv | 30 +++
 rtl/config_loader_byte_assembler.sv | 69 ++++++
 rtl/config_loader.sv | 119 +++++++++++
 tb/tb_config_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : config_loader_pkg
// Purpose  : Shared constants and FSM state encoding for the byte-serial
//            configuration loader of the LFSR pixel generator.
// Revision : 1.0 - initial release
// ============================================================================
package config_loader_pkg;

  // Width of the seed and stop words handed to the LFSR.
  localparam int MAX_PIXEL_BITS = 24;

  // Bytes needed to carry one word over the 8-bit input port.
  localparam int NBYTES = (MAX_PIXEL_BITS + 7) / 8;

  // Loader FSM state; exported so the top level can probe it.
  typedef logic [3:0] cfg_state_t;

  localparam cfg_state_t ST_IDLE       = 4'd0;
  localparam cfg_state_t ST_RX_SEED    = 4'd1;
  localparam cfg_state_t ST_ISSUE_SEED = 4'd2;
  localparam cfg_state_t ST_WAIT_SEED  = 4'd3;
  localparam cfg_state_t ST_RX_STOP    = 4'd4;
  localparam cfg_state_t ST_ISSUE_STOP = 4'd5;
  localparam cfg_state_t ST_WAIT_STOP  = 4'd6;
  localparam cfg_state_t ST_DONE       = 4'd7;
  localparam cfg_state_t ST_ERR        = 4'd8;

endpackage : config_loader_pkg
`default_nettype wire

// File: rtl/config_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : byte_assembler
// Purpose  : Collects bytes (least significant first) into one word. Holds a
//            byte counter, a synchronous clear and a word-complete flag that
//            fires on the transfer carrying the final byte.
// Revision : 1.0 - initial release
// ============================================================================
module byte_assembler
  import config_loader_pkg::*;
#(
  parameter int WORD_BITS = MAX_PIXEL_BITS,
  parameter int NUM_BYTES = (WORD_BITS + 7) / 8
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 clear_i,
  input  logic                 shift_i,
  input  logic [7:0]           byte_i,
  output logic [WORD_BITS-1:0] word_o,
  output logic                 complete_o
);

  localparam int c_cnt_w = $clog2(NUM_BYTES + 1);
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(NUM_BYTES - 1);

  logic [c_cnt_w-1:0]     r_count;
  logic [NUM_BYTES*8-1:0] r_word;
  logic [NUM_BYTES*8-1:0] w_word_next;

  assign complete_o = shift_i && (r_count == c_last_idx);

  // Upper bits of the last byte beyond WORD_BITS are simply not exported.
  assign word_o = r_word[WORD_BITS-1:0];

  // Drop the incoming byte into the lane selected by the byte counter.
  always_comb begin
    w_word_next = r_word;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (r_count == c_cnt_w'(k)) begin
        w_word_next[k*8 +: 8] = byte_i;
      end
    end
  end

  // Byte counter; wraps to zero once the word is complete.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (shift_i) begin
      r_count <= complete_o ? '0 : r_count + 1'b1;
    end
  end

  // Word register; a clear wipes any partially assembled word.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_word <= '0;
    end else if (clear_i) begin
      r_word <= '0;
    end else if (shift_i) begin
      r_word <= w_word_next;
    end
  end

endmodule : byte_assembler
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_loader
// Purpose  : Byte-serial front-end that loads the LFSR seed word and then the
//            stop word, strobing each to the LFSR and waiting for its
//            registered acknowledge, with an acknowledge timeout.
// Revision : 1.0 - initial release
// ============================================================================
module config_loader
  import config_loader_pkg::*;
#(
  // Must be at least 2: the error state appears ACK_TIMEOUT cycles after the
  // strobe, so at least one WAIT cycle is always granted.
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      start_i,
  input  logic [7:0]                byte_i,
  input  logic                      byte_valid_i,
  output logic                      byte_ready_o,
  output logic                      config_o,
  output logic                      config_rdy_o,
  output logic [MAX_PIXEL_BITS-1:0] config_data_o,
  input  logic                      config_done_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o
);

  localparam int c_tmo_w = $clog2(ACK_TIMEOUT + 1);
  // r_tmo is 0 in the first WAIT cycle (one cycle after the strobe), so the
  // last WAIT cycle allowed is the one where r_tmo == ACK_TIMEOUT-2.
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(ACK_TIMEOUT - 2);

  cfg_state_t         r_state;
  cfg_state_t         w_state_next;
  logic [c_tmo_w-1:0] r_tmo;

  logic w_in_rx;
  logic w_in_wait;
  logic w_idle_like;
  logic w_start_ok;
  logic w_shift;
  logic w_clear;
  logic w_word_done;
  logic w_tmo_expire;

  assign w_in_rx      = (r_state == ST_RX_SEED)   || (r_state == ST_RX_STOP);
  assign w_in_wait    = (r_state == ST_WAIT_SEED) || (r_state == ST_WAIT_STOP);
  assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_start_ok   = start_i && w_idle_like;
  assign w_shift      = byte_valid_i && w_in_rx;
  assign w_tmo_expire = w_in_wait && !config_done_i && (r_tmo == c_tmo_last);

  // The assembler is shared: wiped in IDLE, on any accepted start, and once
  // the seed word has been acknowledged.
  assign w_clear = (r_state == ST_IDLE) || w_start_ok
                || ((r_state == ST_WAIT_SEED) && config_done_i);

  byte_assembler #(
    .WORD_BITS (MAX_PIXEL_BITS),
    .NUM_BYTES (NBYTES)
  ) u_byte_assembler (
    .clk_i      (clk_i),
    .nreset_i   (nreset_i),
    .clear_i    (w_clear),
    .shift_i    (w_shift),
    .byte_i     (byte_i),
    .word_o     (config_data_o),
    .complete_o (w_word_done)
  );

  // Next-state decode for the load sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (start_i) w_state_next = ST_RX_SEED;
      ST_RX_SEED:    if (w_word_done) w_state_next = ST_ISSUE_SEED;
      ST_ISSUE_SEED: w_state_next = ST_WAIT_SEED;
      ST_WAIT_SEED: begin
        if (config_done_i)     w_state_next = ST_RX_STOP;
        else if (w_tmo_expire) w_state_next = ST_ERR;
      end
      ST_RX_STOP:    if (w_word_done) w_state_next = ST_ISSUE_STOP;
      ST_ISSUE_STOP: w_state_next = ST_WAIT_STOP;
      ST_WAIT_STOP: begin
        if (config_done_i)     w_state_next = ST_DONE;
        else if (w_tmo_expire) w_state_next = ST_ERR;
      end
      default:       w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) r_state <= ST_IDLE;
    else           r_state <= w_state_next;
  end

  // Acknowledge timeout counter: zero outside WAIT, counts unacknowledged cycles.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)          r_tmo <= '0;
    else if (!w_in_wait)    r_tmo <= '0;
    else if (!config_done_i) r_tmo <= r_tmo + 1'b1;
  end

  // All outputs are pure state decodes, so no input reaches an output
  // combinationally.
  assign byte_ready_o = w_in_rx;
  assign config_rdy_o = (r_state == ST_ISSUE_SEED) || (r_state == ST_ISSUE_STOP);
  assign config_o     = (r_state == ST_RX_STOP) || (r_state == ST_ISSUE_STOP)
                     || (r_state == ST_WAIT_STOP) || (r_state == ST_DONE);
  assign busy_o       = !w_idle_like;
  assign done_o       = (r_state == ST_DONE);
  assign error_o      = (r_state == ST_ERR);

endmodule : config_loader
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_loader
// Purpose  : Directed self-checking bench for config_loader: nominal load,
//            gapped byte stream, acknowledge timeout, ignored inputs and
//            reset in the middle of a word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_loader;
  import config_loader_pkg::*;

  logic                      clk;
  logic                      nreset;
  logic                      start;
  logic [7:0]                byte_in;
  logic                      byte_valid;
  logic                      byte_ready;
  logic                      cfg_sel;
  logic                      cfg_rdy;
  logic [MAX_PIXEL_BITS-1:0] cfg_data;
  logic                      cfg_done;
  logic                      busy;
  logic                      done;
  logic                      error;
  logic                      ack_en;

  int checks   = 0;
  int failures = 0;

  config_loader #(.ACK_TIMEOUT(4)) dut (
    .clk_i         (clk),
    .nreset_i      (nreset),
    .start_i       (start),
    .byte_i        (byte_in),
    .byte_valid_i  (byte_valid),
    .byte_ready_o  (byte_ready),
    .config_o      (cfg_sel),
    .config_rdy_o  (cfg_rdy),
    .config_data_o (cfg_data),
    .config_done_i (cfg_done),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LFSR acknowledge model: registered copy of the ready strobe.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) cfg_done <= 1'b0;
    else         cfg_done <= cfg_rdy & ack_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One byte, then (optionally) three idle cycles with ready still expected.
  task automatic send_gapped(input logic [7:0] b, input bit gap);
    byte_valid = 1'b1;
    byte_in    = b;
    tick();
    byte_valid = 1'b0;
    if (gap) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("gap_ready", {31'd0, byte_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    nreset = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; ack_en = 1'b1;
    tick(); tick();

    // ---------------- reset state ----------------
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_sel",   {31'd0, cfg_sel},    32'd0);
    chk("rst_rdy",   {31'd0, cfg_rdy},    32'd0);
    chk("rst_data",  32'(cfg_data),       32'd0);
    chk("rst_busy",  {31'd0, busy},       32'd0);
    chk("rst_done",  {31'd0, done},       32'd0);
    chk("rst_error", {31'd0, error},      32'd0);
    nreset = 1'b1;
    tick();

    // Bytes offered in IDLE are not taken.
    byte_valid = 1'b1; byte_in = 8'h99;
    tick();
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);
    chk("idle_data",  32'(cfg_data),       32'd0);
    byte_valid = 1'b0;

    // ---------------- nominal load ----------------
    start = 1'b1; tick(); start = 1'b0;               // edge 1: start sampled
    chk("nom_ready_t1", {31'd0, byte_ready}, 32'd1);
    chk("nom_busy",     {31'd0, busy},       32'd1);
    byte_valid = 1'b1;
    byte_in = 8'h56; tick();                          // edge 2
    byte_in = 8'h34; tick();                          // edge 3
    byte_in = 8'h12; tick();                          // edge 4 -> ISSUE_SEED
    chk("nom_seed_rdy",   {31'd0, cfg_rdy},    32'd1);
    chk("nom_seed_sel",   {31'd0, cfg_sel},    32'd0);
    chk("nom_seed_data",  32'(cfg_data),       32'h123456);
    chk("nom_seed_nordy", {31'd0, byte_ready}, 32'd0);
    byte_in = 8'hCD; tick();                          // edge 5 -> WAIT_SEED
    chk("nom_seed_pulse", {31'd0, cfg_rdy}, 32'd0);
    chk("nom_seed_hold",  32'(cfg_data),    32'h123456);
    chk("nom_wait_sel",   {31'd0, cfg_sel}, 32'd0);
    tick();                                           // edge 6 -> RX_STOP
    chk("nom_stop_ready", {31'd0, byte_ready}, 32'd1);
    chk("nom_stop_sel",   {31'd0, cfg_sel},    32'd1);
    chk("nom_stop_clr",   32'(cfg_data),       32'd0);
    tick();                                           // edge 7 takes 0xCD
    byte_in = 8'hAB; tick();                          // edge 8
    byte_in = 8'h00; tick();                          // edge 9 -> ISSUE_STOP
    byte_valid = 1'b0;
    chk("nom_stop_rdy",  {31'd0, cfg_rdy}, 32'd1);
    chk("nom_stop_sel2", {31'd0, cfg_sel}, 32'd1);
    chk("nom_stop_data", 32'(cfg_data),    32'h00ABCD);
    tick();                                           // edge 10 -> WAIT_STOP
    chk("nom_done_early", {31'd0, done}, 32'd0);
    tick();                                           // edge 11: 12th cycle from start
    chk("nom_done",     {31'd0, done},    32'd1);
    chk("nom_done_bsy", {31'd0, busy},    32'd0);
    chk("nom_done_sel", {31'd0, cfg_sel}, 32'd1);

    // Bytes offered in DONE are not taken.
    byte_valid = 1'b1; byte_in = 8'h77;
    tick();
    chk("done_ready", {31'd0, byte_ready}, 32'd0);
    chk("done_data",  32'(cfg_data),       32'h00ABCD);
    chk("done_hold",  {31'd0, done},       32'd1);
    byte_valid = 1'b0;

    // ---------------- gapped stream + ignored start ----------------
    start = 1'b1; tick(); start = 1'b0;
    chk("gap_done_clr", {31'd0, done},       32'd0);
    chk("gap_ready_t1", {31'd0, byte_ready}, 32'd1);
    chk("gap_sel0",     {31'd0, cfg_sel},    32'd0);
    chk("gap_data_clr", 32'(cfg_data),       32'd0);
    send_gapped(8'h56, 1'b1);
    send_gapped(8'h34, 1'b1);
    send_gapped(8'h12, 1'b0);
    chk("gap_seed_rdy",  {31'd0, cfg_rdy}, 32'd1);
    chk("gap_seed_data", 32'(cfg_data),    32'h123456);
    tick(); tick();                                   // WAIT_SEED, RX_STOP
    start = 1'b1; tick(); start = 1'b0;               // ignored while busy
    chk("ign_start_ready", {31'd0, byte_ready}, 32'd1);
    chk("ign_start_sel",   {31'd0, cfg_sel},    32'd1);
    chk("ign_start_busy",  {31'd0, busy},       32'd1);
    send_gapped(8'hCD, 1'b1);
    send_gapped(8'hAB, 1'b1);
    send_gapped(8'h00, 1'b0);
    chk("gap_stop_rdy",  {31'd0, cfg_rdy}, 32'd1);
    chk("gap_stop_sel",  {31'd0, cfg_sel}, 32'd1);
    chk("gap_stop_data", 32'(cfg_data),    32'h00ABCD);
    tick(); tick();
    chk("gap_done", {31'd0, done}, 32'd1);

    // ---------------- acknowledge timeout ----------------
    ack_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'h11; tick();
    byte_in = 8'h22; tick();
    byte_in = 8'h33; tick();                          // seed strobe cycle S
    chk("tmo_rdy",  {31'd0, cfg_rdy}, 32'd1);
    chk("tmo_data", 32'(cfg_data),    32'h332211);
    byte_in = 8'h44;                                  // stop bytes on offer
    tick();                                           // S+1
    chk("tmo_err_s1", {31'd0, error}, 32'd0);
    tick();                                           // S+2
    tick();                                           // S+3
    chk("tmo_err_s3",  {31'd0, error}, 32'd0);
    chk("tmo_busy_s3", {31'd0, busy},  32'd1);
    tick();                                           // S+4
    chk("tmo_err_s4",   {31'd0, error},      32'd1);
    chk("tmo_busy_s4",  {31'd0, busy},       32'd0);
    chk("tmo_ready_s4", {31'd0, byte_ready}, 32'd0);
    tick();
    chk("tmo_sticky",   {31'd0, error},      32'd1);
    chk("tmo_no_stop",  32'(cfg_data),       32'h332211);
    byte_valid = 1'b0;
    ack_en     = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("tmo_err_clr", {31'd0, error},      32'd0);
    chk("tmo_restart", {31'd0, byte_ready}, 32'd1);
    chk("tmo_busy",    {31'd0, busy},       32'd1);

    // ---------------- reset mid-word ----------------
    byte_valid = 1'b1;
    byte_in = 8'hA5; tick();
    byte_in = 8'h5A; tick();
    chk("mid_partial", 32'(cfg_data), 32'h005AA5);
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_data",  32'(cfg_data),       32'd0);
    chk("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy},       32'd0);
    chk("mid_rst_sel",   {31'd0, cfg_sel},    32'd0);
    chk("mid_rst_rdy",   {31'd0, cfg_rdy},    32'd0);
    byte_valid = 1'b0;
    tick();
    nreset = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'hFF; tick();
    chk("mid_no_residue", 32'(cfg_data), 32'h0000FF);
    tick(); tick();
    chk("mid_ff_data", 32'(cfg_data),    32'hFFFFFF);
    chk("mid_ff_rdy",  {31'd0, cfg_rdy}, 32'd1);
    byte_valid = 1'b0;
    tick(); tick();
    chk("mid_to_stop", {31'd0, cfg_sel}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_config_loader
`default_nettype wire
